weight_dma_loader: RTL and testbench



---
 rtl/tpu_pkg.sv | 7 +
 rtl/weight_dma_loader.sv | 85 ++++++++
 tb/tb_weight_dma_loader.sv | 114 +++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared weight-path widths and the loader state encoding
package tpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int NUM_CELLS = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD} wdma_state_t;
endpackage

// File: rtl/weight_dma_loader.sv
// weight_dma_loader: streams host words into consecutive weight cells, then requests a broadcast
module weight_dma_loader
  import tpu_pkg::*;
#(
  parameter int DATA_W = tpu_pkg::DATA_W,
  parameter int ADDR_W = tpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              fetch_w,
  output logic [ADDR_W-1:0] dma_address,
  output logic [DATA_W-1:0] dma_data,
  output logic              load_weight,
  output logic [ADDR_W-1:0] load_addr,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] CELLS = (ADDR_W+1)'(1 << ADDR_W);
  wdma_state_t state;
  logic [ADDR_W:0] n, k, eff_n;
  assign eff_n = (num_words == '0 || num_words > CELLS) ? CELLS : num_words;
  assign in_ready = state == FETCH;
  // busy stays high through the IDLE cycle after LOAD so done and busy-low never coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      n <= '0;
      k <= '0;
      fetch_w <= 1'b0;
      dma_address <= '0;
      dma_data <= '0;
      load_weight <= 1'b0;
      load_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      fetch_w <= 1'b0;
      load_weight <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            load_addr <= base_addr;
            n <= eff_n;
            k <= '0;
            busy <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            busy <= 1'b0;
            state <= IDLE;
          end else if (in_valid) begin
            fetch_w <= 1'b1;
            dma_address <= load_addr + k[ADDR_W-1:0];
            dma_data <= in_data;
            k <= k + 1'b1;
            if (k == n - 1'b1) state <= LOAD;
          end
        end
        LOAD: begin
          if (abort) busy <= 1'b0;
          else begin
            load_weight <= 1'b1;
            done <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_weight_dma_loader.sv
// tb_weight_dma_loader: scoreboard bench for the weight DMA loader
module tb_weight_dma_loader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [5:0] base_addr = '0;
  logic [6:0] num_words = '0;
  logic [15:0] in_data = '0;
  logic in_ready, fetch_w, load_weight, busy, done;
  logic [5:0] dma_address, load_addr;
  logic [15:0] dma_data;
  logic [21:0] exp_w[$];
  logic [5:0] exp_ld[$];
  logic [21:0] e;
  int checks = 0, passed = 0;

  weight_dma_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fetch_w(fetch_w), .dma_address(dma_address), .dma_data(dma_data),
    .load_weight(load_weight), .load_addr(load_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (fetch_w === 1'b1) begin
      if (exp_w.size() == 0) check("fetch_extra", fetch_w, 0);
      else begin
        e = exp_w.pop_front();
        check("dma_addr", dma_address, e[21:16]);
        check("dma_data", dma_data, e[15:0]);
      end
    end
    if (load_weight === 1'b1 || done === 1'b1) begin
      check("ld_done_pair", load_weight, done);
      check("excl", fetch_w, 0);
      if (exp_ld.size() == 0) check("load_extra", load_weight | done, 0);
      else check("load_addr", load_addr, exp_ld.pop_front());
    end
  end

  task automatic xfer(input logic [5:0] b, input logic [6:0] num, input bit toggle,
                      input int stop_at, input bit use_rst, input bit mid_start);
    int eff, cnt, cyc;
    logic [15:0] d;
    eff = (num == 0 || num > 64) ? 64 : int'(num);
    start = 1'b1; base_addr = b; num_words = num;
    @(negedge clk);
    start = 1'b0;
    check("busy_go", busy, 1);
    check("ready_go", in_ready, 1);
    cnt = 0; cyc = 0;
    while (cnt < eff && cnt != stop_at && cyc < 400) begin
      d = 16'h1000 + cnt[15:0];
      in_valid = toggle ? ~cyc[0] : 1'b1;
      in_data = d;
      start = mid_start && cnt == 5;
      if (start) begin base_addr = b ^ 6'h15; num_words = 7'd3; end
      if (in_valid && in_ready) begin
        exp_w.push_back({b + cnt[5:0], d});
        cnt++;
        if (cnt == eff) exp_ld.push_back(b);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    if (cnt == stop_at) begin
      in_valid = 1'b1; in_data = 16'hdead;
      if (use_rst) reset = 1'b1; else abort = 1'b1;
      @(negedge clk);
      if (use_rst)
        check("rst_mid", {busy, in_ready, fetch_w, load_weight, done, dma_address, dma_data, load_addr}, 0);
      else check("abort_ready", in_ready, 0);
      check("stop_busy", busy, 0);
      reset = 1'b0; abort = 1'b0; in_valid = 1'b0;
      repeat (5) @(negedge clk);
    end else if (cnt < eff) check("timeout", cnt, eff);
    else begin
      @(negedge clk);
      check("ld_timing", load_weight, 1);
      @(negedge clk);
      check("busy_end", busy, 0);
      check("no_ld2", load_weight, 0);
    end
    check("drain_w", exp_w.size(), 0);
    check("drain_ld", exp_ld.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {busy, in_ready, fetch_w, load_weight, done, dma_address, dma_data, load_addr}, 0);
    xfer(6'd0, 7'd64, 1'b0, -1, 1'b0, 1'b0);
    xfer(6'd0, 7'd64, 1'b1, -1, 1'b0, 1'b0);
    xfer(6'd60, 7'd8, 1'b0, -1, 1'b0, 1'b0);
    xfer(6'd5, 7'd0, 1'b0, -1, 1'b0, 1'b0);
    xfer(6'd7, 7'd100, 1'b0, -1, 1'b0, 1'b0);
    xfer(6'd63, 7'd1, 1'b0, -1, 1'b0, 1'b0);
    xfer(6'd0, 7'd64, 1'b0, 10, 1'b0, 1'b0);
    xfer(6'd3, 7'd4, 1'b0, -1, 1'b0, 1'b0);
    xfer(6'd20, 7'd12, 1'b0, -1, 1'b0, 1'b1);
    xfer(6'd0, 7'd64, 1'b0, 5, 1'b1, 1'b0);
    xfer(6'd1, 7'd2, 1'b1, -1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
